// File: rtl/sra_unit_if.sv
// sra_unit_if: request/response bundle for the arithmetic-shift-right unit.
//   in_valid / data_in / amount : request, driven by the master (issuer).
//   out_valid / data_out        : registered response, driven by the slave (sra_unit).
// N must match the N of the sra_unit the bundle is connected to.
interface sra_unit_if #(
  parameter int N = 16
) ();
  localparam int SW = $clog2(N);

  logic          in_valid;
  logic [N-1:0]  data_in;
  logic [SW-1:0] amount;
  logic          out_valid;
  logic [N-1:0]  data_out;

  modport master (
    output in_valid, data_in, amount,
    input  out_valid, data_out
  );

  modport slave (
    input  in_valid, data_in, amount,
    output out_valid, data_out
  );
endinterface

// File: rtl/sra_unit.sv
// sra_unit: registered arithmetic shift right (SRA/SRAI datapath slice).
//   clk   : clock, all state on rising edge.
//   rst_n : synchronous active-low reset; clears out_valid and data_out and
//           drops any request presented on the same edge.
//   bus   : sra_unit_if slave port
//             in_valid/data_in/amount -> request, accepted every cycle (no stall)
//             out_valid/data_out      -> result one cycle after acceptance
// Core is a log2(N)-stage barrel shifter; stage k shifts by 2^k when amount[k]
// is set. N must be a power of two and at least 2.

// One barrel stage: shift right by SHIFT and fill vacated MSBs with the
// operand's original sign bit (passed in, not taken from this stage's input,
// so every stage fills with the same bit regardless of earlier stages).
module sraStage #(
  parameter int N     = 16,
  parameter int SHIFT = 1
) (
  input  logic [N-1:0] din,
  input  logic         sign,
  input  logic         en,
  output logic [N-1:0] dout
);
  assign dout = en ? {{SHIFT{sign}}, din[N-1:SHIFT]} : din;
endmodule

module sra_unit #(
  parameter  int N  = 16,
  localparam int SW = $clog2(N)
) (
  input  logic    clk,
  input  logic    rst_n,
  sra_unit_if.slave bus
);
  logic [SW:0][N-1:0] stageData;
  logic               signBit;
  logic               outValidQ;
  logic [N-1:0]       dataOutQ;

  assign signBit      = bus.data_in[N-1];
  assign stageData[0] = bus.data_in;

  for (genvar k = 0; k < SW; k++) begin : gStage
    sraStage #(.N(N), .SHIFT(1 << k)) uStage (
      .din  (stageData[k]),
      .sign (signBit),
      .en   (bus.amount[k]),
      .dout (stageData[k+1])
    );
  end

  // data_out only loads on accepted requests so it holds across idle cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      outValidQ <= 1'b0;
      dataOutQ  <= '0;
    end else begin
      outValidQ <= bus.in_valid;
      if (bus.in_valid) dataOutQ <= stageData[SW];
    end
  end

  assign bus.out_valid = outValidQ;
  assign bus.data_out  = dataOutQ;
endmodule

// File: tb/tb_sra_unit.sv
// tb_sra_unit: directed + random self-check of sra_unit (N=16) using a
// scoreboard queue of expected results.
module tb_sra_unit;
  localparam int N = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sra_unit_if #(.N(N)) bus ();

  sra_unit #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          errors = 0;
  int          checks = 0;
  logic [15:0] expQ[$];
  logic [15:0] lastOut;

  task automatic chk(input logic [15:0] obs, input logic [15:0] exp, input string tag);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, push the expected result when the request
  // will be accepted, then sample #1 after the edge and pop/compare.
  task automatic drive(input bit v, input logic [15:0] d, input logic [3:0] a,
                       input logic [15:0] exp, input string tag);
    bit accepted;
    logic [15:0] e;
    accepted      = v && (rst_n === 1'b1);
    bus.in_valid  = v;
    bus.data_in   = d;
    bus.amount    = a;
    if (accepted) expQ.push_back(exp);
    @(posedge clk);
    #1;
    chk({15'd0, bus.out_valid}, {15'd0, accepted}, {tag, "/vld"});
    if (accepted) begin
      if (expQ.size() == 0) begin
        chk(bus.data_out, 16'hxxxx, {tag, "/noexp"});
      end else begin
        e = expQ.pop_front();
        chk(bus.data_out, e, {tag, "/data"});
        lastOut = e;
      end
    end else if (rst_n !== 1'b1) begin
      chk(bus.data_out, 16'h0000, {tag, "/rstdata"});
      lastOut = 16'h0000;
    end else begin
      chk(bus.data_out, lastOut, {tag, "/hold"});
    end
  endtask

  initial begin
    logic [15:0]        d;
    logic signed [15:0] sd;
    logic [15:0]        ref_;
    lastOut      = 16'h0000;
    bus.in_valid = 1'b0;
    bus.data_in  = '0;
    bus.amount   = '0;
    rst_n        = 1'b0;

    // Reset state, with a request presented during reset (must be dropped).
    drive(1'b1, 16'h8000, 4'd1, 16'h0000, "rst0");
    drive(1'b0, 16'h0000, 4'd0, 16'h0000, "rst1");
    rst_n = 1'b1;
    drive(1'b0, 16'h0000, 4'd0, 16'h0000, "idle0");

    // Negative / positive operands.
    drive(1'b1, 16'h8100, 4'd4, 16'hF810, "neg4");
    drive(1'b1, 16'h0100, 4'd4, 16'h0010, "pos4");

    // Boundaries.
    drive(1'b1, 16'h8001, 4'd0,  16'h8001, "amt0");
    drive(1'b1, 16'h8000, 4'd15, 16'hFFFF, "neg15");
    drive(1'b1, 16'h7FFF, 4'd15, 16'h0000, "pos15");
    drive(1'b1, 16'hFFFF, 4'd7,  16'hFFFF, "ones7");

    // Streaming back-to-back, then idle hold.
    drive(1'b1, 16'hC000, 4'd1, 16'hE000, "strm1");
    drive(1'b1, 16'hC000, 4'd2, 16'hF000, "strm2");
    drive(1'b1, 16'hC000, 4'd3, 16'hF800, "strm3");
    drive(1'b1, 16'hC000, 4'd8, 16'hFFC0, "strm8");
    drive(1'b0, 16'h1234, 4'd5, 16'h0000, "hold0");
    drive(1'b0, 16'h5678, 4'd2, 16'h0000, "hold1");

    // Mid-stream reset: pending valid is cleared, request dropped.
    drive(1'b1, 16'h4000, 4'd2, 16'h1000, "pre");
    rst_n = 1'b0;
    drive(1'b1, 16'h8000, 4'd1, 16'h0000, "midrst");
    rst_n = 1'b1;
    drive(1'b1, 16'h8000, 4'd1, 16'hC000, "postrst");
    drive(1'b0, 16'h0000, 4'd0, 16'h0000, "postidle");

    // Random operands against every amount, checked against a signed reference.
    for (int op = 0; op < 1000; op++) begin
      d = 16'($urandom);
      if (op == 0) d = 16'h8000;
      if (op == 1) d = 16'h7FFF;
      sd = d;
      for (int a = 0; a < 16; a++) begin
        ref_ = 16'(sd >>> a);
        drive(1'b1, d, 4'(a), ref_, "rand");
      end
    end
    drive(1'b0, 16'h0000, 4'd0, 16'h0000, "endidle");

    checks++;
    assert (expQ.size() == 0)
    else begin
      errors++;
      $error("FAIL sbempty: observed=%0d expected=0", expQ.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
